// File: rtl/alu_exec_seq_pkg.sv
// Shared definitions for the sequential ALU execute unit: op_to_alu encodings,
// FSM state encoding and a small op-classification helper.
package alu_exec_seq_pkg;

  // op_to_alu encodings
  localparam logic [2:0] OpRol = 3'b000;
  localparam logic [2:0] OpSll = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpSrl = 3'b011;
  localparam logic [2:0] OpAdd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpAnd = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  // Pass-through requests override the op, so a shift op with passA/passB set
  // is handled by the single-cycle path.
  function automatic logic is_shift_req(logic [2:0] op, logic pass_a, logic pass_b);
    return !op[2] && !pass_a && !pass_b;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift/rotate step.
// Ports:
//   op       - op_to_alu encoding; only rol/sll/sra/srl modify the data
//   data_in  - value before the step
//   data_out - value after one bit of shift/rotate (data_in for non-shift ops)
module alu_shift_step
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (op)
      OpRol:   data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
      OpSll:   data_out = {data_in[WIDTH-2:0], 1'b0};
      OpSra:   data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
      OpSrl:   data_out = {1'b0, data_in[WIDTH-1:1]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Sequential ALU execute unit. Accepts a decoded ALU control bundle plus two
// operands on a valid/ready handshake; logic/arith/pass ops complete in one
// cycle, shifts/rotates iterate one bit per cycle. Result and flags are
// returned on a second valid/ready handshake.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - request handshake
//   A, B                  - operands
//   invA, invB            - invert operand before use
//   cin, sign             - adder carry-in, signed overflow rule select
//   op_to_alu             - operation select
//   passA, passB          - result = Ai / Bi (passB has priority)
//   out_valid / out_ready - result handshake
//   Out, zero, ofl, cout  - registered result and flags
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             invA,
  input  logic             invB,
  input  logic             cin,
  input  logic             sign,
  input  logic [2:0]       op_to_alu,
  input  logic             passA,
  input  logic             passB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             ofl,
  output logic             cout
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         sop_q, sop_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               ofl_q, ofl_d;
  logic               cout_q, cout_d;

  logic [WIDTH-1:0]   ai, bi;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   sum;
  logic               add_cout, add_ofl;
  logic [WIDTH-1:0]   single_res;
  logic               is_add;
  logic               is_shift;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;
  logic [WIDTH-1:0]   step_out;

  // Operand conditioning and single-cycle datapath
  assign ai       = invA ? ~A : A;
  assign bi       = invB ? ~B : B;
  assign sum_ext  = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, cin};
  assign sum      = sum_ext[WIDTH-1:0];
  assign add_cout = sum_ext[WIDTH];
  assign add_ofl  = sign ? ((ai[WIDTH-1] == bi[WIDTH-1]) && (sum[WIDTH-1] != ai[WIDTH-1]))
                         : add_cout;
  assign is_add   = (op_to_alu == OpAdd) && !passA && !passB;
  assign is_shift = is_shift_req(op_to_alu, passA, passB);
  assign shamt    = bi[SHAMT_W-1:0];

  always_comb begin
    single_res = ai;
    if (passB) begin
      single_res = bi;
    end else if (passA) begin
      single_res = ai;
    end else begin
      case (op_to_alu)
        OpAdd:   single_res = sum;
        OpOr:    single_res = ai | bi;
        OpXor:   single_res = ai ^ bi;
        OpAnd:   single_res = ai & bi;
        default: single_res = ai;
      endcase
    end
  end

  alu_shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .op      (sop_q),
    .data_in (shreg_q),
    .data_out(step_out)
  );

  // Handshake
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    out_d   = out_q;
    zero_d  = zero_q;
    ofl_d   = ofl_q;
    cout_d  = cout_q;

    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_shift) begin
            shreg_d = ai;
            cnt_d   = shamt;
            sop_d   = op_to_alu;
            if (shamt == '0) begin
              state_d = StDone;
              out_d   = ai;
              zero_d  = (ai == '0);
              ofl_d   = 1'b0;
              cout_d  = 1'b0;
            end else begin
              state_d = StShift;
            end
          end else begin
            state_d = StDone;
            out_d   = single_res;
            zero_d  = (single_res == '0);
            ofl_d   = is_add ? add_ofl : 1'b0;
            cout_d  = is_add ? add_cout : 1'b0;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StShift: begin
        shreg_d = step_out;
        cnt_d   = cnt_q - SHAMT_W'(1);
        // The final step goes straight into the output register.
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = StDone;
          out_d   = step_out;
          zero_d  = (step_out == '0);
          ofl_d   = 1'b0;
          cout_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      sop_q   <= OpRol;
      out_q   <= '0;
      zero_q  <= 1'b0;
      ofl_q   <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      ofl_q   <= ofl_d;
      cout_q  <= cout_d;
    end
  end

  assign Out  = out_q;
  assign zero = zero_q;
  assign ofl  = ofl_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
module tb_alu_exec_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        invA, invB, cin, sign;
  logic [2:0]  op_to_alu;
  logic        passA, passB;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Out;
  logic        zero, ofl, cout;

  int total = 0;
  int bad   = 0;

  alu_exec_seq #(
    .WIDTH  (16),
    .SHAMT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .invA     (invA),
    .invB     (invB),
    .cin      (cin),
    .sign     (sign),
    .op_to_alu(op_to_alu),
    .passA    (passA),
    .passB    (passB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (Out),
    .zero     (zero),
    .ofl      (ofl),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        inva;
    logic        invb;
    logic        ci;
    logic        sgn;
    logic [2:0]  op;
    logic        pa;
    logic        pb;
    logic [15:0] exp_out;
    logic        exp_zero;
    logic        exp_ofl;
    logic        exp_cout;
    int          exp_wait;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    A         = v.a;
    B         = v.b;
    invA      = v.inva;
    invB      = v.invb;
    cin       = v.ci;
    sign      = v.sgn;
    op_to_alu = v.op;
    passA     = v.pa;
    passB     = v.pb;
  endtask

  // Issue one request from idle, count cycles until out_valid, check result.
  task automatic run_vec(input vec_t v);
    int  waits;
    bit  busy_ok;
    drive(v);
    in_valid = 1'b1;
    chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'hDEAD;  // inputs need not be held
    B = 16'hBEEF;
    waits   = 0;
    busy_ok = 1'b1;
    while (!out_valid && waits < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      waits++;
    end
    chk({v.name, " waits"}, waits, v.exp_wait);
    chk({v.name, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({v.name, " out"}, {16'd0, Out}, {16'd0, v.exp_out});
    chk({v.name, " flags"}, {29'd0, zero, ofl, cout}, {29'd0, v.exp_zero, v.exp_ofl, v.exp_cout});
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string n, logic [15:0] a, logic [15:0] b, logic inva, logic invb,
                              logic ci, logic sgn, logic [2:0] op, logic pa, logic pb,
                              logic [15:0] eo, logic ez, logic eof, logic ec, int ew);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.inva = inva; v.invb = invb; v.ci = ci; v.sgn = sgn;
    v.op = op; v.pa = pa; v.pb = pb; v.exp_out = eo; v.exp_zero = ez; v.exp_ofl = eof;
    v.exp_cout = ec; v.exp_wait = ew;
    return v;
  endfunction

  initial begin
    vec_t v;
    int   cyc;
    bit   seen;

    //            name        A        B        iA iB ci sg op     pA pB out      z  o  c  wait
    vecs.push_back(mk("add_ofl", 16'h7FFF, 16'h0001, 0, 0, 0, 1, 3'b100, 0, 0, 16'h8000, 0, 1, 0, 0));
    vecs.push_back(mk("sub",     16'h0003, 16'h000A, 1, 0, 1, 0, 3'b100, 0, 0, 16'h0007, 0, 1, 1, 0));
    vecs.push_back(mk("sub_eq",  16'h1234, 16'h1234, 1, 0, 1, 0, 3'b100, 0, 0, 16'h0000, 1, 1, 1, 0));
    vecs.push_back(mk("rol4",    16'h8001, 16'h0004, 0, 0, 0, 0, 3'b000, 0, 0, 16'h0018, 0, 0, 0, 4));
    vecs.push_back(mk("rol0",    16'h8001, 16'h0000, 0, 0, 0, 0, 3'b000, 0, 0, 16'h8001, 0, 0, 0, 0));
    vecs.push_back(mk("sra15",   16'h8000, 16'h000F, 0, 0, 0, 0, 3'b010, 0, 0, 16'hFFFF, 0, 0, 0, 15));
    vecs.push_back(mk("srl15",   16'h8000, 16'h000F, 0, 0, 0, 0, 3'b011, 0, 0, 16'h0001, 0, 0, 0, 15));
    vecs.push_back(mk("passB",   16'h1111, 16'h00AB, 0, 0, 0, 0, 3'b100, 0, 1, 16'h00AB, 0, 0, 0, 0));
    vecs.push_back(mk("passA",   16'hABCD, 16'h0003, 0, 0, 0, 0, 3'b001, 1, 0, 16'hABCD, 0, 0, 0, 0));
    vecs.push_back(mk("or",      16'h00F0, 16'h0F00, 0, 0, 0, 0, 3'b101, 0, 0, 16'h0FF0, 0, 0, 0, 0));
    vecs.push_back(mk("and",     16'hF0F0, 16'h0FF0, 0, 0, 0, 0, 3'b111, 0, 0, 16'h00F0, 0, 0, 0, 0));
    vecs.push_back(mk("sll5",    16'h0003, 16'h0005, 0, 0, 0, 0, 3'b001, 0, 0, 16'h0060, 0, 0, 0, 5));
    vecs.push_back(mk("sll_invB",16'h0001, 16'hFFFE, 0, 1, 0, 0, 3'b001, 0, 0, 16'h0002, 0, 0, 0, 1));
    vecs.push_back(mk("add_neg", 16'h8000, 16'h8000, 0, 0, 0, 1, 3'b100, 0, 0, 16'h0000, 1, 1, 1, 0));
    vecs.push_back(mk("add_uns", 16'h0001, 16'hFFFF, 0, 0, 0, 0, 3'b100, 0, 0, 16'h0000, 1, 1, 1, 0));
    vecs.push_back(mk("add_sgn", 16'h0001, 16'hFFFF, 0, 0, 0, 1, 3'b100, 0, 0, 16'h0000, 1, 0, 1, 0));
    vecs.push_back(mk("xor",     16'hF0F0, 16'hFFFF, 0, 0, 0, 0, 3'b110, 0, 0, 16'h0F0F, 0, 0, 0, 0));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk("z", 16'h0, 16'h0, 0, 0, 0, 0, 3'b000, 0, 0, 16'h0, 0, 0, 0, 0));
    #12;
    chk("rst out", {16'd0, Out}, 32'd0);
    chk("rst flags", {29'd0, zero, ofl, cout}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while out_ready=0, then back-to-back accept.
    out_ready = 1'b0;
    drive(mk("bp", 16'h0001, 16'h0001, 0, 0, 0, 0, 3'b100, 0, 0, 16'h0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(mk("nx", 16'hF0F0, 16'hFFFF, 0, 0, 0, 0, 3'b110, 0, 0, 16'h0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      chk("bp out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp out", {16'd0, Out}, 32'h0002);
      chk("bp flags", {29'd0, zero, ofl, cout}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b out", {16'd0, Out}, 32'h0F0F);
    @(posedge clk);
    #1;
    chk("b2b idle", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset mid-shift drops the in-flight result.
    drive(mk("rs", 16'h8000, 16'h000F, 0, 0, 0, 0, 3'b011, 0, 0, 16'h0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst out", {16'd0, Out}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
      cyc++;
    end
    chk("post rst no valid", {31'd0, seen}, 32'd0);
    chk("post rst in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
